// File: rtl/cube_move_sequencer.sv
// Rubik's cube move sequencer: scramble, manual moves and undo driven through an
// external move engine, with a circular undo history and a saturating BCD move counter.
module cube_move_sequencer #(
  parameter int SCRAMBLE_LEN = 30,
  parameter int HIST_DEPTH   = 16,
  parameter int CNT_DIGITS   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_scramble,
  input  logic                    undo,
  input  logic                    man_valid,
  input  logic [2:0]              man_face,
  input  logic [1:0]              man_rot,
  input  logic [2:0]              rand_face,
  input  logic [1:0]              rand_rot,
  input  logic [161:0]            cube_next,
  output logic [161:0]            cube,
  output logic [2:0]              eng_face,
  output logic [2:0]              eng_rot,
  output logic [4*CNT_DIGITS-1:0] move_count,
  output logic [2:0]              state,
  output logic                    busy,
  output logic                    solved,
  output logic [6:0]              hist_count
);

  localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int CW = 4 * CNT_DIGITS;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCRAMBLE = 3'd1,
    S_MOVE     = 3'd2,
    S_UNDO     = 3'd3,
    S_VERIFY   = 3'd4,
    S_SOLVED   = 3'd5
  } state_t;

  state_t         state_q;
  logic [161:0]   cube_q;
  logic [CW-1:0]  cnt_q;
  logic [6:0]     hcnt_q;
  logic [PW-1:0]  head_q;
  logic [5:0]     scr_q;
  logic [2:0]     lface_q;
  logic [1:0]     lrot_q;
  logic [4:0]     hist_q [HIST_DEPTH];

  logic           rand_ok;
  logic           man_ok;
  logic [1:0]     rand_turns;
  logic [1:0]     man_turns;
  logic [4:0]     hist_top;

  function automatic logic [161:0] solved_cube();
    logic [161:0] c;
    c = '0;
    for (int i = 0; i < 54; i++) c[3*i +: 3] = 3'(i / 9);
    return c;
  endfunction

  // Decimal increment; an all-nines counter holds.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    logic          all9;
    all9 = 1'b1;
    for (int d = 0; d < CNT_DIGITS; d++)
      if (v[4*d +: 4] != 4'd9) all9 = 1'b0;
    r     = v;
    carry = !all9;
    for (int d = 0; d < CNT_DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
        else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign rand_ok  = (rand_face <= 3'd5) && (rand_rot != 2'd3);
  assign man_ok   = (man_face <= 3'd5) && (man_rot != 2'd0);
  assign hist_top = hist_q[head_q - PW'(1)];

  always_comb begin
    rand_turns = 2'd0;
    case (rand_rot)
      2'd0:    rand_turns = 2'd1;
      2'd1:    rand_turns = 2'd3;
      2'd2:    rand_turns = 2'd2;
      default: rand_turns = 2'd0;
    endcase
  end

  always_comb begin
    man_turns = 2'd0;
    case (man_rot)
      2'b01:   man_turns = 2'd1;
      2'b10:   man_turns = 2'd3;
      2'b11:   man_turns = 2'd2;
      default: man_turns = 2'd0;
    endcase
  end

  always_comb begin
    eng_face = 3'd0;
    eng_rot  = 3'd0;
    case (state_q)
      S_SCRAMBLE: begin eng_face = rand_face;     eng_rot = {1'b0, rand_turns};    end
      S_MOVE:     begin eng_face = lface_q;       eng_rot = {1'b0, lrot_q};        end
      S_UNDO:     begin eng_face = hist_top[4:2]; eng_rot = {1'b0, hist_top[1:0]}; end
      default:    begin eng_face = 3'd0;          eng_rot = 3'd0;                  end
    endcase
  end

  always_comb begin
    solved = 1'b1;
    for (int f = 0; f < 6; f++)
      for (int s = 0; s < 9; s++)
        if (cube_q[3*(9*f+s) +: 3] != cube_q[3*(9*f+4) +: 3]) solved = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cube_q  <= solved_cube();
      cnt_q   <= '0;
      hcnt_q  <= '0;
      head_q  <= '0;
      scr_q   <= '0;
      lface_q <= '0;
      lrot_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_SOLVED: begin
          if (start_scramble) begin
            state_q <= S_SCRAMBLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            scr_q   <= '0;
          end else if (undo && hcnt_q != 7'd0) begin
            state_q <= S_UNDO;
          end else if (man_valid && man_ok) begin
            lface_q <= man_face;
            lrot_q  <= man_turns;
            state_q <= S_MOVE;
          end
        end
        S_SCRAMBLE: begin
          if (rand_ok) begin
            cube_q <= cube_next;
            scr_q  <= scr_q + 6'd1;
            if (scr_q + 6'd1 == 6'(SCRAMBLE_LEN)) state_q <= S_IDLE;
          end
        end
        S_MOVE: begin
          cube_q  <= cube_next;
          head_q  <= head_q + PW'(1);
          if (hcnt_q != 7'(HIST_DEPTH)) hcnt_q <= hcnt_q + 7'd1;
          cnt_q   <= bcd_inc(cnt_q);
          state_q <= S_VERIFY;
        end
        S_UNDO: begin
          cube_q  <= cube_next;
          head_q  <= head_q - PW'(1);
          hcnt_q  <= hcnt_q - 7'd1;
          cnt_q   <= bcd_inc(cnt_q);
          state_q <= S_VERIFY;
        end
        S_VERIFY: state_q <= solved ? S_SOLVED : S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // History stores the inverse quarter-turn count so undo can replay it directly.
  always_ff @(posedge clk) begin
    if (state_q == S_MOVE) hist_q[head_q] <= {lface_q, 2'(3'd4 - {1'b0, lrot_q})};
  end

  assign cube       = cube_q;
  assign move_count = cnt_q;
  assign state      = state_q;
  assign busy       = !(state_q == S_IDLE || state_q == S_SOLVED);
  assign hist_count = hcnt_q;

endmodule

// File: tb/tb_cube_move_sequencer.sv
// Randomized bench for cube_move_sequencer with a queue-based reference model and a
// toy move engine (a 4-sticker cycle per face) feeding cube_next.
module tb_cube_move_sequencer;

  localparam int HD = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_scramble, undo, man_valid;
  logic [2:0]   man_face, rand_face;
  logic [1:0]   man_rot, rand_rot;
  logic [161:0] cube_next, cube;
  logic [2:0]   eng_face, eng_rot;
  logic [11:0]  move_count;
  logic [2:0]   state;
  logic         busy, solved;
  logic [6:0]   hist_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [161:0] m_cube;
  int           m_cnt;
  int           hq_f[$];
  int           hq_r[$];

  cube_move_sequencer #(.SCRAMBLE_LEN(30), .HIST_DEPTH(HD), .CNT_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start_scramble(start_scramble), .undo(undo),
    .man_valid(man_valid), .man_face(man_face), .man_rot(man_rot),
    .rand_face(rand_face), .rand_rot(rand_rot), .cube_next(cube_next),
    .cube(cube), .eng_face(eng_face), .eng_rot(eng_rot), .move_count(move_count),
    .state(state), .busy(busy), .solved(solved), .hist_count(hist_count)
  );

  always #5 clk = ~clk;

  function automatic logic [161:0] solved_ref();
    logic [161:0] c;
    c = '0;
    for (int i = 0; i < 54; i++) c[3*i +: 3] = 3'(i / 9);
    return c;
  endfunction

  function automatic bit is_solved(input logic [161:0] c);
    for (int f = 0; f < 6; f++)
      for (int s = 0; s < 9; s++)
        if (c[3*(9*f+s) +: 3] != c[3*(9*f+4) +: 3]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [161:0] eng_fn(input logic [161:0] c, input logic [2:0] f,
                                          input logic [2:0] k);
    logic [161:0] r;
    logic [2:0]   tmp;
    int a, b, cc, d, fi;
    r = c;
    if (f > 3'd5) return c;
    fi = int'(f);
    a  = 9 * fi;
    b  = 9 * ((fi + 1) % 6);
    cc = 9 * ((fi + 2) % 6) + 1;
    d  = 9 * ((fi + 3) % 6) + 2;
    for (int t = 0; t < int'(k) % 4; t++) begin
      tmp          = r[3*d +: 3];
      r[3*d +: 3]  = r[3*cc +: 3];
      r[3*cc +: 3] = r[3*b +: 3];
      r[3*b +: 3]  = r[3*a +: 3];
      r[3*a +: 3]  = tmp;
    end
    return r;
  endfunction

  always_comb cube_next = eng_fn(cube, eng_face, eng_rot);

  function automatic logic [11:0] to_bcd(input int v);
    int x;
    x = (v > 999) ? 999 : v;
    return {4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
  endfunction

  function automatic int man_q(input int rot);
    return (rot == 1) ? 1 : (rot == 2) ? 3 : (rot == 3) ? 2 : 0;
  endfunction

  function automatic int rand_q(input int rot);
    return (rot == 0) ? 1 : (rot == 1) ? 3 : (rot == 2) ? 2 : 0;
  endfunction

  function automatic logic [2:0] rest_state();
    return is_solved(m_cube) ? 3'd5 : 3'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cube = solved_ref();
    m_cnt  = 0;
    hq_f.delete();
    hq_r.delete();
  endtask

  task automatic model_move(input int f, input int q);
    m_cube = eng_fn(m_cube, 3'(f), 3'(q));
    hq_f.push_back(f);
    hq_r.push_back((4 - q) % 4);
    if (hq_f.size() > HD) begin
      void'(hq_f.pop_front());
      void'(hq_r.pop_front());
    end
    m_cnt++;
  endtask

  task automatic model_undo();
    int f, r;
    if (hq_f.size() == 0) return;
    f = hq_f.pop_back();
    r = hq_r.pop_back();
    m_cube = eng_fn(m_cube, 3'(f), 3'(r));
    m_cnt++;
  endtask

  task automatic do_manual(input int f, input int rot);
    man_face  = 3'(f);
    man_rot   = 2'(rot);
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    tick();
    tick();
    if (f <= 5 && rot != 0) model_move(f, man_q(rot));
  endtask

  task automatic do_undo();
    undo = 1'b1;
    tick();
    undo = 1'b0;
    tick();
    tick();
    model_undo();
  endtask

  task automatic run_scramble_legal();
    int cyc, f, r;
    cyc = 0;
    while (state == 3'd1 && cyc < 100) begin
      cyc++;
      f = $urandom_range(0, 5);
      r = $urandom_range(0, 2);
      rand_face = 3'(f);
      rand_rot  = 2'(r);
      m_cube = eng_fn(m_cube, 3'(f), 3'(rand_q(r)));
      tick();
    end
    m_cnt = 0;
    hq_f.delete();
    hq_r.delete();
    n_checks++;
    if (cyc != 30) begin
      n_fail++;
      $display("FAIL scramble_len: got %0d cycles, expected 30", cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_scramble = 0; undo = 0; man_valid = 0;
    man_face = 0; man_rot = 0; rand_face = 0; rand_rot = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    model_reset();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (solved !== 1'b1) begin n_fail++; $display("FAIL reset_solved: got %b expected 1", solved); end
    n_checks++; if (move_count !== 12'h000) begin n_fail++; $display("FAIL reset_count: got %h expected 000", move_count); end
    n_checks++; if (hist_count !== 7'd0) begin n_fail++; $display("FAIL reset_hist: got %0d expected 0", hist_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (cube !== m_cube) begin n_fail++; $display("FAIL reset_cube: got %h expected %h", cube, m_cube); end
  endtask

  task automatic test_manual_undo();
    man_face = 3'd2; man_rot = 2'b01; man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL mv_state: got %0d expected 2", state); end
    n_checks++; if (eng_face !== 3'd2 || eng_rot !== 3'd1) begin n_fail++; $display("FAIL mv_eng: got %0d/%0d expected 2/1", eng_face, eng_rot); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mv_busy: got %b expected 1", busy); end
    tick();
    model_move(2, 1);
    n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL mv_verify: got %0d expected 4", state); end
    n_checks++; if (cube !== m_cube) begin n_fail++; $display("FAIL mv_cube: got %h expected %h", cube, m_cube); end
    tick();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL mv_idle: got %0d expected 0", state); end
    n_checks++; if (move_count !== 12'h001) begin n_fail++; $display("FAIL mv_count: got %h expected 001", move_count); end
    n_checks++; if (hist_count !== 7'd1) begin n_fail++; $display("FAIL mv_hist: got %0d expected 1", hist_count); end
    undo = 1'b1;
    tick();
    undo = 1'b0;
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL un_state: got %0d expected 3", state); end
    n_checks++; if (eng_face !== 3'd2 || eng_rot !== 3'd3) begin n_fail++; $display("FAIL un_eng: got %0d/%0d expected 2/3", eng_face, eng_rot); end
    tick();
    tick();
    model_undo();
    n_checks++; if (state !== 3'd5) begin n_fail++; $display("FAIL un_solved_state: got %0d expected 5", state); end
    n_checks++; if (move_count !== 12'h002) begin n_fail++; $display("FAIL un_count: got %h expected 002", move_count); end
    n_checks++; if (hist_count !== 7'd0) begin n_fail++; $display("FAIL un_hist: got %0d expected 0", hist_count); end
    n_checks++; if (cube !== solved_ref() || solved !== 1'b1) begin n_fail++; $display("FAIL un_cube: got %h solved=%b expected solved cube", cube, solved); end
  endtask

  task automatic test_scramble();
    int cyc, f, r;
    start_scramble = 1'b1;
    tick();
    start_scramble = 1'b0;
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL scr_enter: got %0d expected 1", state); end
    cyc = 0;
    while (state == 3'd1 && cyc < 100) begin
      cyc++;
      f = $urandom_range(0, 5);
      r = (cyc == 5 || cyc == 9) ? 3 : $urandom_range(0, 2);
      rand_face = 3'(f);
      rand_rot  = 2'(r);
      if (r != 3) m_cube = eng_fn(m_cube, 3'(f), 3'(rand_q(r)));
      tick();
    end
    m_cnt = 0;
    hq_f.delete();
    hq_r.delete();
    n_checks++; if (cyc != 32) begin n_fail++; $display("FAIL scr_cycles: got %0d expected 32", cyc); end
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL scr_exit: got %0d expected 0", state); end
    n_checks++; if (cube !== m_cube) begin n_fail++; $display("FAIL scr_cube: got %h expected %h", cube, m_cube); end
    n_checks++; if (move_count !== 12'h000 || hist_count !== 7'd0) begin n_fail++; $display("FAIL scr_counts: got %h/%0d expected 000/0", move_count, hist_count); end
  endtask

  task automatic test_history_wrap();
    int ef, er;
    for (int i = 0; i < 18; i++) do_manual($urandom_range(0, 5), $urandom_range(1, 3));
    n_checks++; if (hist_count !== 7'(hq_f.size())) begin n_fail++; $display("FAIL hw_hist: got %0d expected %0d", hist_count, hq_f.size()); end
    n_checks++; if (hist_count !== 7'd16) begin n_fail++; $display("FAIL hw_sat: got %0d expected 16", hist_count); end
    n_checks++; if (cube !== m_cube) begin n_fail++; $display("FAIL hw_cube: got %h expected %h", cube, m_cube); end
    for (int i = 0; i < 16; i++) begin
      ef = hq_f[$];
      er = hq_r[$];
      undo = 1'b1;
      tick();
      undo = 1'b0;
      n_checks++;
      if (state !== 3'd3 || eng_face !== 3'(ef) || eng_rot !== 3'(er)) begin
        n_fail++;
        $display("FAIL hw_undo%0d: got st=%0d eng=%0d/%0d expected st=3 eng=%0d/%0d", i, state, eng_face, eng_rot, ef, er);
      end
      tick();
      tick();
      model_undo();
    end
    n_checks++; if (cube !== m_cube) begin n_fail++; $display("FAIL hw_undo_cube: got %h expected %h", cube, m_cube); end
    n_checks++; if (hist_count !== 7'd0) begin n_fail++; $display("FAIL hw_empty: got %0d expected 0", hist_count); end
    undo = 1'b1;
    tick();
    undo = 1'b0;
    n_checks++; if (state !== rest_state()) begin n_fail++; $display("FAIL hw_17th: got %0d expected %0d", state, rest_state()); end
    tick();
    n_checks++; if (move_count !== to_bcd(m_cnt)) begin n_fail++; $display("FAIL hw_count: got %h expected %h", move_count, to_bcd(m_cnt)); end
  endtask

  task automatic test_random_ops();
    int op;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if (op <= 1) do_manual($urandom_range(0, 5), $urandom_range(1, 3));
      else if (op == 2) do_undo();
      else if ($urandom_range(0, 1) == 1) do_manual($urandom_range(6, 7), $urandom_range(0, 3));
      else do_manual($urandom_range(0, 5), 0);
      n_checks++;
      if (cube !== m_cube || move_count !== to_bcd(m_cnt) || hist_count !== 7'(hq_f.size()) || state !== rest_state()) begin
        n_fail++;
        $display("FAIL rnd%0d: got cnt=%h hist=%0d st=%0d cube=%h expected cnt=%h hist=%0d st=%0d cube=%h",
                 i, move_count, hist_count, state, cube, to_bcd(m_cnt), hq_f.size(), rest_state(), m_cube);
      end
    end
  endtask

  task automatic test_reject_and_priority();
    logic [2:0] exp_st;
    exp_st = rest_state();
    man_face = 3'd6; man_rot = 2'b01; man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    n_checks++; if (state !== exp_st) begin n_fail++; $display("FAIL rej_face: got %0d expected %0d", state, exp_st); end
    man_face = 3'd2; man_rot = 2'b00; man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    n_checks++; if (state !== exp_st) begin n_fail++; $display("FAIL rej_rot: got %0d expected %0d", state, exp_st); end
    n_checks++; if (cube !== m_cube) begin n_fail++; $display("FAIL rej_cube: got %h expected %h", cube, m_cube); end
    start_scramble = 1'b1; man_valid = 1'b1; man_face = 3'd1; man_rot = 2'b01;
    tick();
    start_scramble = 1'b0; man_valid = 1'b0;
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL prio: got %0d expected 1", state); end
    run_scramble_legal();
    n_checks++; if (cube !== m_cube || move_count !== 12'h000) begin n_fail++; $display("FAIL prio_scr: got cnt=%h cube=%h expected 000 %h", move_count, cube, m_cube); end
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 1000; i++) begin
      do_manual($urandom_range(0, 5), $urandom_range(1, 3));
      if (i == 100 || i == 999 || i == 1000) begin
        n_checks++;
        if (move_count !== to_bcd(m_cnt)) begin
          n_fail++;
          $display("FAIL sat_%0d: got %h expected %h", i, move_count, to_bcd(m_cnt));
        end
      end
    end
    n_checks++; if (move_count !== 12'h999) begin n_fail++; $display("FAIL sat_hold: got %h expected 999", move_count); end
    n_checks++; if (cube !== m_cube || hist_count !== 7'd16) begin n_fail++; $display("FAIL sat_cube: got hist=%0d expected 16", hist_count); end
  endtask

  task automatic test_reset_mid();
    man_face = 3'd3; man_rot = 2'b11; man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (state !== 3'd0 || cube !== solved_ref()) begin n_fail++; $display("FAIL rstmv: got st=%0d cube=%h expected 0 solved", state, cube); end
    n_checks++; if (move_count !== 12'h000 || hist_count !== 7'd0) begin n_fail++; $display("FAIL rstmv_cnt: got %h/%0d expected 000/0", move_count, hist_count); end
    tick();
    rst = 1'b0;
    model_reset();
    start_scramble = 1'b1;
    tick();
    start_scramble = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_face = 3'($urandom_range(0, 5));
      rand_rot  = 2'($urandom_range(0, 2));
      tick();
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (state !== 3'd0 || cube !== solved_ref() || busy !== 1'b0) begin n_fail++; $display("FAIL rstscr: got st=%0d busy=%b expected 0/0 solved cube", state, busy); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (state !== 3'd0 || solved !== 1'b1) begin n_fail++; $display("FAIL rst_release: got st=%0d solved=%b expected 0/1", state, solved); end
  endtask

  initial begin
    test_reset();
    test_manual_undo();
    test_scramble();
    test_history_wrap();
    test_random_ops();
    test_reject_and_priority();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cube_move_sequencer.md
CUBE_MOVE_SEQUENCER -- requirements
Module: cube_move_sequencer

Interface
REQ-001 Parameter SCRAMBLE_LEN, default 30: random moves applied per scramble, range 1..63.
REQ-002 Parameter HIST_DEPTH, default 16: undo history entries, power of two, range 2..64.
REQ-003 Parameter CNT_DIGITS, default 3: BCD digits of the move counter, range 1..4.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 start_scramble  input  1: level, request a scramble.
REQ-007 undo  input  1: level, request reversal of the last recorded move.
REQ-008 man_valid  input  1: level, manual move request.
REQ-009 man_face  input  3: manual face, 0..5 legal.
REQ-010 man_rot  input  2: 00 none, 01 CW, 10 CCW, 11 double.
REQ-011 rand_face  input  3: random face from generator, 0..5 legal.
REQ-012 rand_rot  input  2: 0 CW, 1 CCW, 2 double, 3 illegal.
REQ-013 cube_next  input  162: move-engine result for cube, eng_face, eng_rot.
REQ-014 cube  output  162: current cube, 54 stickers x 3 bits, sticker i at [3i+2:3i].
REQ-015 eng_face  output  3: face driven to the move engine.
REQ-016 eng_rot  output  3: quarter-turn count driven to the move engine (0..3).
REQ-017 move_count  output  4*CNT_DIGITS: BCD move counter, digit 0 in the LSBs.
REQ-018 state  output  3: IDLE=0, SCRAMBLE=1, MOVE=2, UNDO=3, VERIFY=4, SOLVED=5.
REQ-019 busy  output  1: high in every state except IDLE and SOLVED.
REQ-020 solved  output  1: combinational; high when all 9 stickers of every face equal that face's sticker 4.
REQ-021 hist_count  output  7: number of valid history entries.

Function
REQ-022 In IDLE and SOLVED, request priority is start_scramble > undo > man_valid; at most one request is accepted per cycle.
REQ-023 On accepting start_scramble: go to SCRAMBLE; clear move_count, hist_count and the scramble counter.
REQ-024 In SCRAMBLE: eng_face=rand_face; eng_rot maps rand_rot 0->1, 1->3, 2->2.
REQ-025 In SCRAMBLE, legal random move: cube<=cube_next and the scramble counter increments.
REQ-026 In SCRAMBLE, rand_face>5 or rand_rot=3: the cycle is skipped; cube and the scramble counter hold.
REQ-027 When the scramble counter reaches SCRAMBLE_LEN: go to IDLE in the next cycle; scramble moves are never recorded or counted.
REQ-028 man_valid is accepted in IDLE/SOLVED only if man_face<=5 and man_rot!=00; otherwise it is ignored and the state holds.
REQ-029 On acceptance, face and rotation are latched (01->1, 10->3, 11->2) and the next state is MOVE.
REQ-030 MOVE (1 cycle): drives the latched move on eng_*; cube<=cube_next.
REQ-031 MOVE also pushes the inverse move (1<->3, 2->2) into history and increments move_count; cube updates at the end of the cycle after acceptance.
REQ-032 History is circular: push when hist_count=HIST_DEPTH overwrites the oldest entry; hist_count saturates at HIST_DEPTH.
REQ-033 undo is accepted only if hist_count>0 (otherwise ignored). The next state is UNDO (1 cycle): pops the newest entry and drives it on eng_*.
REQ-034 In UNDO: cube<=cube_next; hist_count decrements; move_count increments.
REQ-035 move_count increments in BCD with decimal carry; at all-9s it saturates.
REQ-036 VERIFY always follows MOVE or UNDO: solved=1 -> SOLVED, else IDLE.
REQ-037 SOLVED behaves as IDLE for request acceptance; cube, move_count and history hold.
REQ-038 In IDLE, VERIFY and SOLVED: eng_face=0 and eng_rot=0.
REQ-039 Requests arriving while busy are not queued.

Reset
REQ-040 While rst=1, regardless of clk: state=IDLE; cube=solved (sticker i = i/9); move_count=0; hist_count=0; scramble counter=0; latched move=0.
REQ-041 Reset asserted mid-SCRAMBLE, MOVE or UNDO aborts the operation with no partial cube update.

Verification
REQ-042 Reset release, no inputs -> state=0, solved=1, move_count=0, hist_count=0, busy=0.
REQ-043 start_scramble one cycle, generator gives legal moves with rand_rot=3 on cycles 5 and 9 -> exactly 30 cube updates, SCRAMBLE lasts 32 cycles, then IDLE, move_count=0.
REQ-044 Solved cube, man_face=2, man_rot=01 -> MOVE, VERIFY, IDLE; move_count=001, hist_count=1.
REQ-045 Then undo -> UNDO drives eng_face=2, eng_rot=3; VERIFY -> SOLVED; move_count=002, hist_count=0.
REQ-046 18 legal manual moves with HIST_DEPTH=16 -> hist_count=16; 16 undos each accepted, a 17th ignored.
REQ-047 move_count preloaded to 999 via moves, one more move -> stays 999; man_face=6 or man_rot=00 -> ignored; start_scramble and man_valid together -> SCRAMBLE.
